ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - async-SRAM controller: single writes, single reads and a clear-all sweep
module ram_ctrl #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [1:0] CMD,
  input  logic [4:0] HADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  inout  wire  [7:0] DATA,
  output logic [4:0] ADDR,
  output logic       OE,
  output logic       CS,
  output logic       WS
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [2:0] WAIT_LAST = (READ_WAIT == 0) ? 3'd0 : 3'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_ENABLE,
    R_WAIT,
    R_CAPTURE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] wait_q, wait_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_q, cs_d;
  logic       oe_q, oe_d;
  logic       ws_q, ws_d;
  logic       drive_q, drive_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    oe_d    = oe_q;
    ws_d    = ws_q;
    drive_d = drive_q;

    case (state_q)
      IDLE: begin
        if (REQ && (CMD != 2'b00)) begin
          cmd_d  = CMD;
          busy_d = 1'b1;
          cs_d   = 1'b0;
          if (CMD == CMD_READ) begin
            state_d = R_ENABLE;
            addr_d  = HADDR;
            oe_d    = 1'b1;
          end else begin
            state_d = W_SETUP;
            addr_d  = (CMD == CMD_WRITE) ? HADDR : 5'd0;
            wdata_d = (CMD == CMD_WRITE) ? WDATA : 8'h00;
            drive_d = 1'b1;
          end
        end
      end
      W_SETUP: begin
        state_d = W_STROBE;
        ws_d    = 1'b1;
      end
      W_STROBE: begin
        state_d = W_HOLD;
        ws_d    = 1'b0;
      end
      W_HOLD: begin
        // The clear sweep reuses the address register as its counter.
        if ((cmd_q == CMD_CLEAR) && (addr_q != 5'd31)) begin
          state_d = W_SETUP;
          addr_d  = addr_q + 5'd1;
        end else begin
          state_d = IDLE;
          cs_d    = 1'b1;
          drive_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      R_ENABLE: begin
        if (READ_WAIT == 0) begin
          state_d = R_CAPTURE;
        end else begin
          state_d = R_WAIT;
          wait_d  = WAIT_LAST;
        end
      end
      R_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = R_CAPTURE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      R_CAPTURE: begin
        state_d = IDLE;
        rdata_d = DATA;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        ws_d    = 1'b0;
        drive_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q   <= 2'b00;
      addr_q  <= 5'd0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      wait_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b0;
      ws_q    <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      ws_q    <= ws_d;
      drive_q <= drive_d;
    end
  end

  assign DATA  = drive_q ? wdata_q : 8'bz;
  assign RDATA = rdata_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ADDR  = addr_q;
  assign OE    = oe_q;
  assign CS    = cs_q;
  assign WS    = ws_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - directed bench for ram_ctrl with an async SRAM model and bus monitor
module tb_ram_ctrl;

  localparam int RW = 1;

  logic       CLK = 1'b0;
  logic       RST, REQ;
  logic [1:0] CMD;
  logic [4:0] HADDR;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       BUSY, DONE, OE, CS, WS;
  logic [4:0] ADDR;
  wire  [7:0] data_bus;

  logic [7:0] mem [32];
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int done_tot = 0;
  int ws_tot   = 0;
  int oe_tot   = 0;
  int viol     = 0;

  ram_ctrl #(.READ_WAIT(RW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CMD(CMD), .HADDR(HADDR), .WDATA(WDATA),
    .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE), .DATA(data_bus), .ADDR(ADDR),
    .OE(OE), .CS(CS), .WS(WS)
  );

  always #5 CLK = ~CLK;

  // SRAM model: drives the bus on an enabled read, writes on the WS rising edge
  assign data_bus = (!CS && OE) ? mem[ADDR] : 8'bz;
  assign data_bus = probe_en ? probe_val : 8'bz;

  always @(posedge WS) begin
    if (!CS) mem[ADDR] <= data_bus;
  end

  // Bus monitor, sampled shortly after each rising edge
  always begin
    @(posedge CLK);
    #2;
    if (DONE) done_tot = done_tot + 1;
    if (WS) ws_tot = ws_tot + 1;
    if (OE) oe_tot = oe_tot + 1;
    if (OE && WS) viol = viol + 1;
    if (OE && !CS && (data_bus !== mem[ADDR])) viol = viol + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives two values onto the bus; each reads back unchanged only if nothing else drives it
  task automatic probe_z(input string tag);
    probe_en  = 1'b1;
    probe_val = 8'h00;
    #1 check_eq({tag, "_z0"}, {24'd0, data_bus}, 32'h00);
    probe_val = 8'h81;
    #1 check_eq({tag, "_z1"}, {24'd0, data_bus}, 32'h81);
    probe_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK);
    REQ   = 1'b1;
    CMD   = c;
    HADDR = a;
    WDATA = d;
    @(negedge CLK);
    REQ = 1'b0;
    CMD = 2'b00;
  endtask

  // Called at the first negedge after acceptance (cycle 1); returns at the DONE cycle
  task automatic wait_done(input string tag, input int exp_cycle);
    int n;
    n = 1;
    while (DONE !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n = n + 1;
    end
    check_eq(tag, n, exp_cycle);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    issue(2'b10, a, d);
    wait_done("wr_done", 4);
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
    issue(2'b01, a, 8'h00);
    wait_done({tag, "_done"}, 3 + RW);
    check_eq(tag, {24'd0, RDATA}, {24'd0, exp});
  endtask

  initial begin
    int snap_done, snap_ws, snap_oe, sweep_err;
    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    RST = 1'b1; REQ = 1'b1; CMD = 2'b01; HADDR = 5'd9; WDATA = 8'h77;

    // Reset held two cycles with a pending request
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_cs", CS, 1);
    check_eq("rst_oe", OE, 0);
    check_eq("rst_ws", WS, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_addr", ADDR, 0);
    probe_z("rst");
    RST = 1'b0; REQ = 1'b0; CMD = 2'b00;

    // Write A5 to 7, cycle by cycle
    snap_ws = ws_tot;
    issue(2'b10, 5'd7, 8'hA5);
    check_eq("wsu_busy", BUSY, 1);
    check_eq("wsu_cs", CS, 0);
    check_eq("wsu_ws", WS, 0);
    check_eq("wsu_addr", ADDR, 7);
    check_eq("wsu_data", data_bus, 8'hA5);
    @(negedge CLK);
    check_eq("wst_ws", WS, 1);
    check_eq("wst_data", data_bus, 8'hA5);
    @(negedge CLK);
    check_eq("wh_ws", WS, 0);
    check_eq("wh_data", data_bus, 8'hA5);
    check_eq("wh_done", DONE, 0);
    @(negedge CLK);
    check_eq("w_done", DONE, 1);
    check_eq("w_busy", BUSY, 0);
    check_eq("w_cs", CS, 1);
    check_eq("w_ws_cnt", ws_tot - snap_ws, 1);
    probe_z("w_idle");
    @(negedge CLK);
    check_eq("w_done_pulse", DONE, 0);

    // Read 7 back
    snap_oe = oe_tot;
    do_read("rd7", 5'd7, 8'hA5);
    check_eq("rd7_oe_cycles", oe_tot - snap_oe, 2 + RW);
    check_eq("rd7_oe_off", OE, 0);

    // A new request in the DONE cycle is accepted
    issue(2'b10, 5'd20, 8'h5A);
    wait_done("b2b_wr", 4);
    REQ = 1'b1; CMD = 2'b01; HADDR = 5'd20;
    @(negedge CLK);
    REQ = 1'b0; CMD = 2'b00;
    check_eq("b2b_oe", OE, 1);
    wait_done("b2b_rd_done", 3 + RW);
    check_eq("b2b_rd", RDATA, 8'h5A);

    // Clear-all sweep
    do_write(5'd0, 8'h3C);
    do_write(5'd31, 8'h3C);
    do_read("pre_clr0", 5'd0, 8'h3C);
    do_read("pre_clr31", 5'd31, 8'h3C);
    snap_done = done_tot;
    snap_ws   = ws_tot;
    sweep_err = 0;
    issue(2'b11, 5'd9, 8'h99);
    for (int i = 0; i < 32; i++) begin
      if (ADDR !== 5'(i)) sweep_err = sweep_err + 1;
      for (int k = 0; k < 3; k++) begin
        if (BUSY !== 1'b1 || DONE !== 1'b0) sweep_err = sweep_err + 1;
        @(negedge CLK);
      end
    end
    check_eq("clr_sweep", sweep_err, 0);
    check_eq("clr_done", DONE, 1);
    check_eq("clr_busy_end", BUSY, 0);
    check_eq("clr_ws_cnt", ws_tot - snap_ws, 32);
    repeat (3) @(negedge CLK);
    check_eq("clr_done_cnt", done_tot - snap_done, 1);
    do_read("clr0", 5'd0, 8'h00);
    do_read("clr15", 5'd15, 8'h00);
    do_read("clr31", 5'd31, 8'h00);

    // Request during a busy write is ignored
    snap_done = done_tot;
    snap_oe   = oe_tot;
    issue(2'b10, 5'd5, 8'h11);
    @(negedge CLK);
    check_eq("bsy_ws", WS, 1);
    REQ = 1'b1; CMD = 2'b01; HADDR = 5'd5;
    @(negedge CLK);
    REQ = 1'b0; CMD = 2'b00;
    @(negedge CLK);
    check_eq("bsy_done", DONE, 1);
    repeat (6) @(negedge CLK);
    check_eq("bsy_done_cnt", done_tot - snap_done, 1);
    check_eq("bsy_oe_cnt", oe_tot - snap_oe, 0);
    check_eq("bsy_rdata", RDATA, 8'h00);
    do_read("bsy_rd5", 5'd5, 8'h11);

    // Reset in W_STROBE aborts without DONE; the strobed write stays
    snap_done = done_tot;
    issue(2'b10, 5'd3, 8'hFF);
    @(negedge CLK);
    check_eq("mrst_ws_pre", WS, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("mrst_ws", WS, 0);
    check_eq("mrst_cs", CS, 1);
    check_eq("mrst_busy", BUSY, 0);
    check_eq("mrst_done", DONE, 0);
    check_eq("mrst_rdata", RDATA, 8'h00);
    probe_z("mrst");
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check_eq("mrst_done_cnt", done_tot - snap_done, 0);
    do_read("mrst_rd3", 5'd3, 8'hFF);

    repeat (2) @(negedge CLK);
    check_eq("bus_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
